truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/tts_pkg.sv | 15 +
 rtl/tts_sync2.sv | 24 ++
 rtl/truth_table_sweeper.sv | 131 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tts_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tts_pkg;

    localparam int unsigned N_VECTORS = 8;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StSettle,
        StSample,
        StDone
    } tts_state_e;

endpackage

// File: rtl/tts_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module tts_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a 3-bit vector through 0..7, waits for the circuit to settle, and captures a dual-rail
// truth table. Define TTS_ERR_ABORT_EN to end the sweep at the first dual-rail violation.
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned SETTLE_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     drv_in,
    input  logic                 sense_out1,
    input  logic                 sense_out2,
    output logic [N_VECTORS-1:0] tt_out1,
    output logic [N_VECTORS-1:0] tt_out2,
    output logic [N_VECTORS-1:0] err_mask
);

`ifdef TTS_ERR_ABORT_EN
    localparam bit ErrAbort = 1'b1;
`else
    localparam bit ErrAbort = 1'b0;
`endif

    localparam logic [SETTLE_W-1:0] SettleLoad = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0]    LastIdx    = IDX_W'(N_VECTORS - 1);

    tts_state_e           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [SETTLE_W-1:0]  cnt_q, cnt_d;
    logic [N_VECTORS-1:0] tt1_q, tt1_d;
    logic [N_VECTORS-1:0] tt2_q, tt2_d;
    logic [N_VECTORS-1:0] err_q, err_d;
    logic                 s1_sync, s2_sync;
    logic                 viol;

    tts_sync2 u_sync_out1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sense_out1),
        .q     (s1_sync)
    );

    tts_sync2 u_sync_out2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sense_out2),
        .q     (s2_sync)
    );

    // Both rails equal means the circuit is neither cleanly 0 nor 1.
    assign viol = (s1_sync == s2_sync);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt1_d   = tt1_q;
        tt2_d   = tt2_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    tt1_d   = '0;
                    tt2_d   = '0;
                    err_d   = '0;
                    idx_d   = '0;
                    state_d = StApply;
                end
            end
            StApply: begin
                cnt_d   = SettleLoad;
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSample: begin
                tt1_d[idx_q] = s1_sync;
                tt2_d[idx_q] = s2_sync;
                err_d[idx_q] = viol;
                if (idx_q == LastIdx || (ErrAbort && viol)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StApply;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            tt1_q   <= '0;
            tt2_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt1_q   <= tt1_d;
            tt2_q   <= tt2_d;
            err_q   <= err_d;
        end
    end

    // The index doubles as the drive vector, so drv_in holds its last value between sweeps.
    assign drv_in   = idx_q;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign tt_out1  = tt1_q;
    assign tt_out2  = tt2_q;
    assign err_mask = err_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: one sweeper with SETTLE_CYCLES=16 on an ideal circuit model, one with
// SETTLE_CYCLES=2 on a model whose outputs lag drv_in by one clock.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       stuck = 1'b0;

    logic       busy_a, done_a, busy_b, done_b;
    logic [2:0] drv_a, drv_b, drv_b_del;
    logic [7:0] tt1_a, tt2_a, err_a, tt1_b, tt2_b, err_b;
    logic       s1_a, s2_a, s1_b, s2_b;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] drv_log [32];

    always #5 clk = ~clk;

    function automatic logic model_f(input logic [2:0] v);
        return (~v[2] & v[1]) | (v[0] & ~v[1]);
    endfunction

    assign s2_a = model_f(drv_a);
    assign s1_a = stuck ? 1'b0 : ~model_f(drv_a);

    always @(posedge clk) drv_b_del <= drv_b;
    assign s2_b = model_f(drv_b_del);
    assign s1_b = ~model_f(drv_b_del);

    truth_table_sweeper #(
        .SETTLE_CYCLES (16),
        .SETTLE_W      (16)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_a),
        .busy       (busy_a),
        .done       (done_a),
        .drv_in     (drv_a),
        .sense_out1 (s1_a),
        .sense_out2 (s2_a),
        .tt_out1    (tt1_a),
        .tt_out2    (tt2_a),
        .err_mask   (err_a)
    );

    truth_table_sweeper #(
        .SETTLE_CYCLES (2),
        .SETTLE_W      (4)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .busy       (busy_b),
        .done       (done_b),
        .drv_in     (drv_b),
        .sense_out1 (s1_b),
        .sense_out2 (s2_b),
        .tt_out1    (tt1_b),
        .tt_out2    (tt2_b),
        .err_mask   (err_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Raises start at the current negedge; returns the negedge count at which done is seen, or -1.
    task automatic run_sweep(input bit sel, input bit hold, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        while (!seen && lat < 400) begin
            @(negedge clk);
            lat++;
            if (!hold) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if (sel && lat <= 32) drv_log[lat-1] = drv_b;
            seen = sel ? done_b : done_a;
        end
        if (!seen) lat = -1;
    endtask

    initial begin
        int lat;
        int lat2;
        int guard;

        #12;
        check_eq("rst_busy", {31'b0, busy_a}, 32'd0);
        check_eq("rst_done", {31'b0, done_a}, 32'd0);
        check_eq("rst_drv", {29'b0, drv_a}, 32'd0);
        check_eq("rst_tables", {8'b0, tt1_a, tt2_a, err_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Short settle with lagging circuit: stepping, latency, tables
        run_sweep(1'b1, 1'b0, lat);
        check_eq("b_latency", lat, 32'd33);
        check_eq("b_tt2", {24'b0, tt2_b}, 32'h2E);
        check_eq("b_tt1", {24'b0, tt1_b}, 32'hD1);
        check_eq("b_err", {24'b0, err_b}, 32'h00);
        for (int i = 0; i < 32; i++) begin
            check_eq($sformatf("b_drv_step%0d", i), {29'b0, drv_log[i]}, i / 4);
        end

        // Nominal sweep
        @(negedge clk);
        run_sweep(1'b0, 1'b0, lat);
        check_eq("a_latency", lat, 32'd145);
        check_eq("a_tt2", {24'b0, tt2_a}, 32'h2E);
        check_eq("a_tt1", {24'b0, tt1_a}, 32'hD1);
        check_eq("a_err", {24'b0, err_a}, 32'h00);
        @(negedge clk);
        check_eq("a_done_pulse", {31'b0, done_a}, 32'd0);
        check_eq("a_idle_busy", {31'b0, busy_a}, 32'd0);
        repeat (10) @(negedge clk);
        check_eq("a_hold_tt2", {24'b0, tt2_a}, 32'h2E);
        check_eq("a_hold_drv", {29'b0, drv_a}, 32'd7);

        // sense_out1 stuck low
        stuck = 1'b1;
        run_sweep(1'b0, 1'b0, lat);
`ifdef TTS_ERR_ABORT_EN
        check_eq("stuck_latency", lat, 32'd19);
        check_eq("stuck_err", {24'b0, err_a}, 32'h01);
        check_eq("stuck_tt2", {24'b0, tt2_a}, 32'h00);
`else
        check_eq("stuck_latency", lat, 32'd145);
        check_eq("stuck_err", {24'b0, err_a}, 32'hD1);
        check_eq("stuck_tt2", {24'b0, tt2_a}, 32'h2E);
`endif
        check_eq("stuck_tt1", {24'b0, tt1_a}, 32'h00);
        stuck = 1'b0;
        @(negedge clk);

        // start held high across two sweeps
        run_sweep(1'b0, 1'b1, lat);
        check_eq("hold_lat1", lat, 32'd145);
        @(negedge clk);
        check_eq("hold_idle_busy", {31'b0, busy_a}, 32'd0);
        check_eq("hold_idle_done", {31'b0, done_a}, 32'd0);
        run_sweep(1'b0, 1'b1, lat2);
        check_eq("hold_lat2", lat2, 32'd145);
        check_eq("hold_tt2", {24'b0, tt2_a}, 32'h2E);
        check_eq("hold_tt1", {24'b0, tt1_a}, 32'hD1);
        start_a = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during the settle phase of vector 3
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_eq("mid_busy", {31'b0, busy_a}, 32'd1);
        guard = 0;
        while (drv_a != 3'd3 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq("mid_reach_v3", {29'b0, drv_a}, 32'd3);
        repeat (3) @(negedge clk);
        check_eq("mid_partial_tt2", {24'b0, tt2_a}, 32'h06);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", {31'b0, busy_a}, 32'd0);
        check_eq("mid_rst_drv", {29'b0, drv_a}, 32'd0);
        check_eq("mid_rst_tables", {8'b0, tt1_a, tt2_a, err_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(1'b0, 1'b0, lat);
        check_eq("post_rst_latency", lat, 32'd145);
        check_eq("post_rst_tt2", {24'b0, tt2_a}, 32'h2E);
        check_eq("post_rst_tt1", {24'b0, tt1_a}, 32'hD1);
        check_eq("post_rst_err", {24'b0, err_a}, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
